// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one AXI4-Lite master port between the icache fill port
// (read-only) and the LSU data port (read/write). One transaction outstanding;
// a grant is held from address issue until its response handshake.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin icache/LSU arbitration;
// otherwise fixed priority with the LSU ahead of the icache.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // icache fill read
  input  logic                icache_arvalid_i,
  output logic                icache_arready_o,
  input  logic [ADDR_W-1:0]   icache_araddr_i,
  output logic                icache_rvalid_o,
  input  logic                icache_rready_i,
  output logic [DATA_W-1:0]   icache_rdata_o,
  output logic [1:0]          icache_rresp_o,
  // LSU read
  input  logic                lsu_arvalid_i,
  output logic                lsu_arready_o,
  input  logic [ADDR_W-1:0]   lsu_araddr_i,
  output logic                lsu_rvalid_o,
  input  logic                lsu_rready_i,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic [1:0]          lsu_rresp_o,
  // LSU write
  input  logic                lsu_awvalid_i,
  output logic                lsu_awready_o,
  input  logic [ADDR_W-1:0]   lsu_awaddr_i,
  input  logic                lsu_wvalid_i,
  output logic                lsu_wready_o,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_bvalid_o,
  input  logic                lsu_bready_i,
  output logic [1:0]          lsu_bresp_o,
  // bus master
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  output logic [ADDR_W-1:0]   m_araddr_o,
  input  logic                m_rvalid_i,
  output logic                m_rready_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_bvalid_i,
  output logic                m_bready_o,
  input  logic [1:0]          m_bresp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    I_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   ar_done_q, aw_done_q, w_done_q;
  logic   ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic   lsu_req;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_icache_q;  // 1 when the icache held the most recent grant
`endif

  assign lsu_req = lsu_arvalid_i | lsu_awvalid_i;
  assign ar_hs   = m_arvalid_o & m_arready_i;
  assign aw_hs   = m_awvalid_o & m_awready_i;
  assign w_hs    = m_wvalid_o & m_wready_i;
  assign r_hs    = m_rvalid_i & m_rready_o;
  assign b_hs    = m_bvalid_i & m_bready_o;

  // State register, per-transaction handshake flags and arbitration history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_icache_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        ar_done_q <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (ar_hs) ar_done_q <= 1'b1;
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if ((state_q != IDLE) && (state_d == IDLE)) last_icache_q <= (state_q == I_RD);
`endif
    end
  end

  // Next state: grant in IDLE, release on the response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (icache_arvalid_i && (!lsu_req || !last_icache_q)) state_d = I_RD;
`else
        if (icache_arvalid_i && !lsu_req) state_d = I_RD;
`endif
        else if (lsu_arvalid_i) state_d = D_RD;
        else if (lsu_awvalid_i) state_d = D_WR;
      end
      I_RD, D_RD: if (r_hs) state_d = IDLE;
      D_WR:       if (b_hs) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Outputs: route handshakes of the granted port only; payloads pass through
  always_comb begin
    m_arvalid_o      = 1'b0;
    m_rready_o       = 1'b0;
    m_awvalid_o      = 1'b0;
    m_wvalid_o       = 1'b0;
    m_bready_o       = 1'b0;
    icache_arready_o = 1'b0;
    icache_rvalid_o  = 1'b0;
    lsu_arready_o    = 1'b0;
    lsu_rvalid_o     = 1'b0;
    lsu_awready_o    = 1'b0;
    lsu_wready_o     = 1'b0;
    lsu_bvalid_o     = 1'b0;
    m_araddr_o       = (state_q == I_RD) ? icache_araddr_i : lsu_araddr_i;
    m_awaddr_o       = lsu_awaddr_i;
    m_wdata_o        = lsu_wdata_i;
    m_wstrb_o        = lsu_wstrb_i;
    icache_rdata_o   = m_rdata_i;
    icache_rresp_o   = m_rresp_i;
    lsu_rdata_o      = m_rdata_i;
    lsu_rresp_o      = m_rresp_i;
    lsu_bresp_o      = m_bresp_i;
    case (state_q)
      I_RD: begin
        m_arvalid_o      = icache_arvalid_i & ~ar_done_q;
        icache_arready_o = m_arready_i & ~ar_done_q;
        m_rready_o       = icache_rready_i & ar_done_q;
        icache_rvalid_o  = m_rvalid_i & ar_done_q;
      end
      D_RD: begin
        m_arvalid_o   = lsu_arvalid_i & ~ar_done_q;
        lsu_arready_o = m_arready_i & ~ar_done_q;
        m_rready_o    = lsu_rready_i & ar_done_q;
        lsu_rvalid_o  = m_rvalid_i & ar_done_q;
      end
      D_WR: begin
        m_awvalid_o   = lsu_awvalid_i & ~aw_done_q;
        lsu_awready_o = m_awready_i & ~aw_done_q;
        m_wvalid_o    = lsu_wvalid_i & ~w_done_q;
        lsu_wready_o  = m_wready_i & ~w_done_q;
        m_bready_o    = lsu_bready_i & aw_done_q & w_done_q;
        lsu_bvalid_o  = m_bvalid_i & aw_done_q & w_done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level arbitration model and a simple AXI4-Lite slave model.
module tb_mem_arbiter;
  localparam int LIM = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_arvalid, icache_arready, icache_rvalid, icache_rready;
  logic [31:0] icache_araddr, icache_rdata;
  logic [1:0]  icache_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [1:0]  lsu_bresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_arvalid_i(icache_arvalid), .icache_arready_o(icache_arready), .icache_araddr_i(icache_araddr),
    .icache_rvalid_o(icache_rvalid), .icache_rready_i(icache_rready), .icache_rdata_o(icache_rdata),
    .icache_rresp_o(icache_rresp),
    .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready), .lsu_araddr_i(lsu_araddr),
    .lsu_rvalid_o(lsu_rvalid), .lsu_rready_i(lsu_rready), .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp),
    .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready), .lsu_awaddr_i(lsu_awaddr),
    .lsu_wvalid_i(lsu_wvalid), .lsu_wready_o(lsu_wready), .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb),
    .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready), .lsu_bresp_o(lsu_bresp),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          ar_wt = 0, r_wt = 0, aw_wt = 0, w_wt = 0;
  int          ar_cnt, aw_cnt, w_cnt, r_dly;
  bit          r_pend, aw_got, w_got;
  int          w_hs_cnt = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  logic [31:0] s_waddr, s_wdata;
  logic [3:0]  s_wstrb;

  function automatic logic [31:0] sdata(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  assign m_arready = m_arvalid && (ar_cnt >= ar_wt);
  assign m_awready = m_awvalid && (aw_cnt >= aw_wt);
  assign m_wready  = m_wvalid && (w_cnt >= w_wt);

  // Response code of every transaction is taken from address bits [3:2]
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_dly <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      m_rvalid <= 1'b0; m_bvalid <= 1'b0;
      m_rdata <= 32'h0; m_rresp <= 2'b00; m_bresp <= 2'b00;
      s_waddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0;
    end else begin
      ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
      if (m_arvalid && m_arready) begin
        m_rdata <= use_fixed ? fixed_rdata : sdata(m_araddr);
        m_rresp <= m_araddr[3:2];
        if (r_wt == 0) m_rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_dly <= r_wt - 1; end
      end else if (r_pend) begin
        if (r_dly == 0) begin m_rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_dly <= r_dly - 1;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; s_waddr <= m_awaddr; end
      if (m_wvalid && m_wready) begin
        w_got <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb; w_hs_cnt <= w_hs_cnt + 1;
      end
      if ((aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready)) && !m_bvalid) begin
        m_bvalid <= 1'b1;
        m_bresp  <= (m_awvalid && m_awready) ? m_awaddr[3:2] : s_waddr[3:2];
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
    end
  end

  // ---------------- protocol monitor ----------------
  bit i_rsp = 1'b0, d_rsp = 1'b0, b_rsp = 1'b0;
  int spurious = 0, overlap = 0, bpulses = 0;

  // Responses may only reach a port that is waiting for one; bus valids never overlap
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (icache_rvalid && !i_rsp) spurious++;
      if (lsu_rvalid && !d_rsp) spurious++;
      if (lsu_bvalid && !b_rsp) spurious++;
      if (lsu_bvalid) bpulses++;
      if (m_arvalid && (m_awvalid || m_wvalid)) overlap++;
    end
  end

  // ---------------- requesters ----------------
  int served[$];     // 0 icache read, 1 LSU read, 2 LSU write
  int exp_order[$];
  bit m_last_i = 1'b0;

  task automatic icache_read(input logic [31:0] a);
    int n;
    logic [31:0] exp_d;
    exp_d = use_fixed ? fixed_rdata : sdata(a);
    icache_arvalid = 1'b1; icache_araddr = a; icache_rready = 1'b1;
    n = 0; #1;
    while (!icache_arready && n < LIM) begin @(negedge clk); #1; n++; end
    check("icache ar wait", 64'(n >= LIM), 64'(0));
    @(negedge clk); icache_arvalid = 1'b0; i_rsp = 1'b1; #1;
    n = 0;
    while (!icache_rvalid && n < LIM) begin @(negedge clk); #1; n++; end
    check("icache r wait", 64'(n >= LIM), 64'(0));
    check("icache rdata", 64'(icache_rdata), 64'(exp_d));
    check("icache rresp", 64'(icache_rresp), 64'(a[3:2]));
    served.push_back(0);
    @(negedge clk); icache_rready = 1'b0; i_rsp = 1'b0;
  endtask

  task automatic lsu_read(input logic [31:0] a);
    int n;
    lsu_arvalid = 1'b1; lsu_araddr = a; lsu_rready = 1'b1;
    n = 0; #1;
    while (!lsu_arready && n < LIM) begin @(negedge clk); #1; n++; end
    check("lsu ar wait", 64'(n >= LIM), 64'(0));
    @(negedge clk); lsu_arvalid = 1'b0; d_rsp = 1'b1; #1;
    n = 0;
    while (!lsu_rvalid && n < LIM) begin @(negedge clk); #1; n++; end
    check("lsu r wait", 64'(n >= LIM), 64'(0));
    check("lsu rdata", 64'(lsu_rdata), 64'(sdata(a)));
    check("lsu rresp", 64'(lsu_rresp), 64'(a[3:2]));
    served.push_back(1);
    @(negedge clk); lsu_rready = 1'b0; d_rsp = 1'b0;
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    bit aw_p, w_p, ah, wh;
    lsu_awvalid = 1'b1; lsu_awaddr = a; lsu_wvalid = 1'b1; lsu_wdata = d; lsu_wstrb = s;
    lsu_bready = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; n = 0; #1;
    while ((aw_p || w_p) && n < LIM) begin
      ah = lsu_awvalid && lsu_awready;
      wh = lsu_wvalid && lsu_wready;
      @(negedge clk);
      if (ah) begin lsu_awvalid = 1'b0; aw_p = 1'b0; end
      if (wh) begin lsu_wvalid = 1'b0; w_p = 1'b0; end
      #1; n++;
    end
    check("lsu aw/w wait", 64'(n >= LIM), 64'(0));
    b_rsp = 1'b1;
    n = 0;
    while (!lsu_bvalid && n < LIM) begin @(negedge clk); #1; n++; end
    check("lsu b wait", 64'(n >= LIM), 64'(0));
    check("lsu bresp", 64'(lsu_bresp), 64'(a[3:2]));
    check("bus awaddr", 64'(s_waddr), 64'(a));
    check("bus wdata", 64'(s_wdata), 64'(d));
    check("bus wstrb", 64'(s_wstrb), 64'(s));
    served.push_back(2);
    @(negedge clk); lsu_bready = 1'b0; b_rsp = 1'b0;
  endtask

  // Expected service order when every port keeps its next request pending
  function automatic void model_order(input int ni, input int nd, input int nw);
    bit lsu, pick_i;
    exp_order.delete();
    while (ni + nd + nw > 0) begin
      lsu = (nd > 0) || (nw > 0);
`ifdef ARB_ROUND_ROBIN_EN
      pick_i = (ni > 0) && (!lsu || !m_last_i);
`else
      pick_i = (ni > 0) && !lsu;
`endif
      if (pick_i) begin exp_order.push_back(0); ni--; m_last_i = 1'b1; end
      else if (nd > 0) begin exp_order.push_back(1); nd--; m_last_i = 1'b0; end
      else begin exp_order.push_back(2); nw--; m_last_i = 1'b0; end
    end
  endfunction

  function automatic logic [31:0] raddr();
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic run_stream(input int ni, input int nd, input int nw);
    model_order(ni, nd, nw);
    served.delete();
    @(negedge clk);
    fork
      for (int k = 0; k < ni; k++) icache_read(raddr());
      for (int k = 0; k < nd; k++) lsu_read(raddr());
      for (int k = 0; k < nw; k++) lsu_write(raddr(), $urandom, 4'($urandom_range(1, 15)));
    join
    check("served count", 64'(served.size()), 64'(exp_order.size()));
    for (int k = 0; k < exp_order.size(); k++)
      check($sformatf("grant order %0d", k), 64'((k < served.size()) ? served[k] : -1), 64'(exp_order[k]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int w0, b0;
    icache_arvalid = 1'b1; icache_araddr = 32'h0; icache_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_rready = 1'b0;
    lsu_awvalid = 1'b0; lsu_awaddr = 32'h0; lsu_wvalid = 1'b0; lsu_wdata = 32'h0;
    lsu_wstrb = 4'h0; lsu_bready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset valids/readies", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
          icache_arready, icache_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
          lsu_bvalid}), 64'(0));
    @(negedge clk); icache_arvalid = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // lone icache read with zero-wait slave
    use_fixed = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
    icache_arvalid = 1'b1; icache_araddr = 32'h8000_0010; icache_rready = 1'b1;
    #1; check("t1 m_arvalid N", 64'(m_arvalid), 64'(0));
    @(negedge clk); #1;
    check("t1 m_arvalid N+1", 64'(m_arvalid), 64'(1));
    check("t1 m_araddr", 64'(m_araddr), 64'(32'h8000_0010));
    check("t1 icache_arready", 64'(icache_arready), 64'(1));
    @(negedge clk); icache_arvalid = 1'b0; i_rsp = 1'b1; #1;
    check("t1 rvalid N+2", 64'(icache_rvalid), 64'(1));
    check("t1 rdata", 64'(icache_rdata), 64'(32'hDEAD_BEEF));
    check("t1 rresp", 64'(icache_rresp), 64'(0));
    check("t1 lsu_rvalid", 64'(lsu_rvalid), 64'(0));
    @(negedge clk); icache_rready = 1'b0; i_rsp = 1'b0; #1;
    check("t1 rvalid after", 64'(icache_rvalid), 64'(0));
    use_fixed = 1'b0; m_last_i = 1'b1;

    // LSU write, slave accepts w two cycles before aw
    aw_wt = 2; w_wt = 0; w0 = w_hs_cnt; b0 = bpulses;
    @(negedge clk);
    lsu_write(32'h8000_0100, 32'h1234_5678, 4'hF);
    check("t2 w handshakes", 64'(w_hs_cnt - w0), 64'(1));
    check("t2 b pulses", 64'(bpulses - b0), 64'(1));
    aw_wt = 0; m_last_i = 1'b0;

    // simultaneous icache/LSU reads, LSU streaming 4 reads; then 2+2
    run_stream(1, 4, 0);
    run_stream(2, 2, 0);
    // LSU read and write together
    run_stream(0, 1, 1);

    // DECERR passes through, next request served normally
    @(negedge clk); icache_read(32'h8000_002C); m_last_i = 1'b1;
    @(negedge clk); icache_read(32'h8000_0040); m_last_i = 1'b1;

    // reset in D_WR with m_awvalid high
    aw_wt = 20; w_wt = 20;
    @(negedge clk);
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0200; lsu_wvalid = 1'b1; lsu_wdata = 32'hCAFE_0001;
    lsu_wstrb = 4'h3;
    @(negedge clk); #1;
    check("rst pre m_awvalid", 64'(m_awvalid), 64'(1));
    #1; rst_n = 1'b0; #1;
    check("rst m_awvalid drop", 64'(m_awvalid), 64'(0));
    check("rst m_wvalid drop", 64'(m_wvalid), 64'(0));
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    aw_wt = 0; w_wt = 0;
    @(negedge clk); rst_n = 1'b1; m_last_i = 1'b0;
    run_stream(1, 0, 0);

    // randomized streams with random slave wait states
    for (int r = 0; r < 24; r++) begin
      int ni, nd, nw;
      ar_wt = $urandom_range(0, 2); r_wt = $urandom_range(0, 2);
      aw_wt = $urandom_range(0, 2); w_wt = $urandom_range(0, 2);
      ni = $urandom_range(0, 2); nd = $urandom_range(0, 2); nw = $urandom_range(0, 2);
      if (ni + nd + nw == 0) ni = 1;
      run_stream(ni, nd, nw);
    end

    @(negedge clk);
    check("spurious responses", 64'(spurious), 64'(0));
    check("bus valid overlap", 64'(overlap), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
